// File: rtl/add8u_sched_pkg.sv
// Shared constants and scheduler state type for the round-robin 8-bit adder.
package add8u_sched_pkg;
    localparam int NREQ_MAX = 8;
    localparam int OPW      = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sched_state_e;
endpackage

// File: rtl/add8u_core.sv
// Combinational 8-bit unsigned adder with 9-bit result (carry-out in O[8]).
// Macro ADD8U_APPROX_LSB_EN: OR the LSBs and drop the bit-0 carry into bit 1.
module add8u_core
    import add8u_sched_pkg::*;
(
    input  logic [OPW-1:0] A,
    input  logic [OPW-1:0] B,
    output logic [OPW:0]   O
);

`ifdef ADD8U_APPROX_LSB_EN
    assign O[0]     = A[0] | B[0];
    assign O[OPW:1] = {1'b0, A[OPW-1:1]} + {1'b0, B[OPW-1:1]};
`else
    assign O = {1'b0, A} + {1'b0, B};
`endif

endmodule

// File: rtl/add8u_rr_sched.sv
// NREQ requesters share one add8u_core through a round-robin arbiter feeding a
// one-entry result register. LSB approximation selected by ADD8U_APPROX_LSB_EN.
module add8u_rr_sched
    import add8u_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [OPW:0]        rsp_sum,
    output logic [IDW-1:0]      rsp_id
);

    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("add8u_rr_sched: NREQ out of range");
    end

    sched_state_e   r_state;
    sched_state_e   w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [OPW:0]   r_sum;
    logic [IDW-1:0] r_id;

    logic           w_can_accept;
    logic           w_found;
    logic           w_hs;
    logic [IDW-1:0] w_gnt_idx;
    logic [IDW-1:0] w_ptr_nxt;
    logic [OPW-1:0] w_a;
    logic [OPW-1:0] w_b;
    logic [OPW:0]   w_sum;

    // Lowest valid index at or above ptr wins; otherwise the lowest valid index overall.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found   = 1'b1;
                w_gnt_idx = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(r_ptr))) begin
                w_gnt_idx = IDW'(i);
            end
        end
    end

    // Reset gates acceptance so no ready escapes while rst_n is low.
    assign w_can_accept = rst_n && ((r_state == EMPTY) || rsp_ready);
    assign w_hs         = w_can_accept && w_found;
    assign w_ptr_nxt    = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_a       = '0;
        w_b       = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_a          = req_a[i*OPW +: OPW];
                w_b          = req_b[i*OPW +: OPW];
                req_ready[i] = w_hs;
            end
        end
    end

    add8u_core u_core (
        .A (w_a),
        .B (w_b),
        .O (w_sum)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_hs) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && rsp_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_ptr <= w_ptr_nxt;
                r_sum <= w_sum;
                r_id  <= w_gnt_idx;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;

endmodule
